// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between the issue stage, the execute ALU and the MEM stage.
// Upstream and downstream both sit on the master side; the ALU is the slave.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            flush_I;
  logic            valid_I;
  logic            ready_O;
  logic [3:0]      aluFunc_I;
  logic [XLEN-1:0] opA_I;
  logic [XLEN-1:0] opB_I;
  logic            valid_O;
  logic            ready_I;
  logic [XLEN-1:0] result_O;
  logic            zero_O;

  modport master (
    output flush_I, valid_I, aluFunc_I, opA_I, opB_I, ready_I,
    input  ready_O, valid_O, result_O, zero_O
  );

  modport slave (
    input  flush_I, valid_I, aluFunc_I, opA_I, opB_I, ready_I,
    output ready_O, valid_O, result_O, zero_O
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops, and a bit-serial
// shifter that moves one bit per cycle, with valid/ready on both sides.
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic           clk_I,
  input  logic           rst_I,
  alu_exec_unit_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [3:0] F_ADD  = 4'b0000;
  localparam logic [3:0] F_SUB  = 4'b0001;
  localparam logic [3:0] F_SLL  = 4'b0010;
  localparam logic [3:0] F_SRA  = 4'b0011;
  localparam logic [3:0] F_SRL  = 4'b0100;
  localparam logic [3:0] F_AND  = 4'b0101;
  localparam logic [3:0] F_OR   = 4'b0110;
  localparam logic [3:0] F_XOR  = 4'b0111;
  localparam logic [3:0] F_SLT  = 4'b1000;
  localparam logic [3:0] F_SLTU = 4'b1001;

  state_t              state_q;
  logic [XLEN-1:0]     work_q;
  logic [XLEN-1:0]     result_q;
  logic [SHAMT_W-1:0]  count_q;
  logic [3:0]          op_q;
  logic                valid_q;
  logic                zero_q;

  logic                slot_free;
  logic                accept;
  logic                is_shift;
  logic [SHAMT_W-1:0]  shamt;
  logic [XLEN-1:0]     alu_d;
  logic [XLEN-1:0]     shift_d;

  assign shamt     = bus.opB_I[SHAMT_W-1:0];
  assign slot_free = !valid_q || bus.ready_I;
  assign bus.ready_O = (state_q == IDLE) && slot_free && !bus.flush_I;
  assign accept    = bus.valid_I && bus.ready_O;
  assign is_shift  = (bus.aluFunc_I == F_SLL) || (bus.aluFunc_I == F_SRL) ||
                     (bus.aluFunc_I == F_SRA);

  assign bus.valid_O  = valid_q;
  assign bus.result_O = result_q;
  assign bus.zero_O   = zero_q;

  // Shift codes only reach this path with shamt == 0, so they pass A through.
  always_comb begin
    alu_d = '0;
    case (bus.aluFunc_I)
      F_ADD:  alu_d = bus.opA_I + bus.opB_I;
      F_SUB:  alu_d = bus.opA_I - bus.opB_I;
      F_SLL,
      F_SRL,
      F_SRA:  alu_d = bus.opA_I;
      F_AND:  alu_d = bus.opA_I & bus.opB_I;
      F_OR:   alu_d = bus.opA_I | bus.opB_I;
      F_XOR:  alu_d = bus.opA_I ^ bus.opB_I;
      F_SLT:  alu_d = {{(XLEN-1){1'b0}}, ($signed(bus.opA_I) < $signed(bus.opB_I))};
      F_SLTU: alu_d = {{(XLEN-1){1'b0}}, (bus.opA_I < bus.opB_I)};
      default: alu_d = '0;
    endcase
  end

  // One-bit shift of the working register; the MSB fill distinguishes SRA from SRL.
  for (genvar gi = 0; gi < XLEN; gi++) begin : g_shift
    logic lo_bit;
    logic hi_bit;
    if (gi == 0) begin : g_lsb
      assign lo_bit = 1'b0;
    end else begin : g_lo
      assign lo_bit = work_q[gi-1];
    end
    if (gi == XLEN-1) begin : g_msb
      assign hi_bit = (op_q == F_SRA) ? work_q[XLEN-1] : 1'b0;
    end else begin : g_hi
      assign hi_bit = work_q[gi+1];
    end
    assign shift_d[gi] = (op_q == F_SLL) ? lo_bit : hi_bit;
  end

  always_ff @(posedge clk_I) begin
    if (rst_I) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      count_q  <= '0;
      work_q   <= '0;
      op_q     <= F_ADD;
    end else if (bus.flush_I) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      if (valid_q && bus.ready_I) valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              work_q  <= bus.opA_I;
              count_q <= shamt;
              op_q    <= bus.aluFunc_I;
              state_q <= SHIFT;
            end else begin
              result_q <= alu_d;
              zero_q   <= (alu_d == '0);
              valid_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (count_q == SHAMT_W'(1)) begin
            // Final step only completes into a free output slot.
            if (slot_free) begin
              result_q <= shift_d;
              zero_q   <= (shift_d == '0);
              valid_q  <= 1'b1;
              count_q  <= '0;
              state_q  <= IDLE;
            end
          end else begin
            work_q  <= shift_d;
            count_q <= count_q - SHAMT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, immediate assertions.
module tb_alu_exec_unit;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   lat;
  logic busy_bad;

  alu_exec_unit_if #(.XLEN(32)) bus ();

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk_I (clk),
    .rst_I (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.valid_I   = 1'b1;
    bus.aluFunc_I = f;
    bus.opA_I     = a;
    bus.opB_I     = b;
  endtask

  // Accept one op, then count edges after the accept edge until valid_O rises.
  task automatic run_shift(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    drive(f, a, b);
    tick();
    bus.valid_I = 1'b0;
    lat = 0;
    busy_bad = 1'b0;
    while (!bus.valid_O && lat < 64) begin
      if (bus.ready_O !== 1'b0) busy_bad = 1'b1;
      tick();
      lat++;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.flush_I = 1'b0;
    bus.valid_I = 1'b0;
    bus.aluFunc_I = 4'b0000;
    bus.opA_I = '0;
    bus.opB_I = '0;
    bus.ready_I = 1'b1;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", {31'b0, bus.valid_O}, 32'd0);
    chk("rst_zero", {31'b0, bus.zero_O}, 32'd1);
    chk("rst_result", bus.result_O, 32'd0);
    #1;
    chk("rst_ready", {31'b0, bus.ready_O}, 32'd1);

    // Single-cycle ops, streamed
    drive(4'b0000, 32'h7FFF_FFFF, 32'h1);
    tick();
    chk("add_valid", {31'b0, bus.valid_O}, 32'd1);
    chk("add_result", bus.result_O, 32'h8000_0000);
    chk("add_zero", {31'b0, bus.zero_O}, 32'd0);
    drive(4'b0001, 32'd5, 32'd5);
    tick();
    chk("sub_result", bus.result_O, 32'd0);
    chk("sub_zero", {31'b0, bus.zero_O}, 32'd1);
    drive(4'b1000, 32'hFFFF_FFFF, 32'h1);
    tick();
    chk("slt_result", bus.result_O, 32'd1);
    chk("slt_valid", {31'b0, bus.valid_O}, 32'd1);
    drive(4'b1001, 32'hFFFF_FFFF, 32'h1);
    tick();
    chk("sltu_result", bus.result_O, 32'd0);
    bus.valid_I = 1'b0;
    tick();
    chk("consume_valid", {31'b0, bus.valid_O}, 32'd0);

    // Shifts
    run_shift(4'b0011, 32'h8000_0000, 32'd4);
    chk("sra_latency", lat, 32'd4);
    chk("sra_result", bus.result_O, 32'hF800_0000);
    chk("sra_busy", {31'b0, busy_bad}, 32'd0);
    tick();
    run_shift(4'b0100, 32'h8000_0000, 32'd31);
    chk("srl_latency", lat, 32'd31);
    chk("srl_result", bus.result_O, 32'h0000_0001);
    chk("srl_busy", {31'b0, busy_bad}, 32'd0);
    tick();
    run_shift(4'b0010, 32'h0000_0001, 32'd0);
    chk("sll0_latency", lat, 32'd0);
    chk("sll0_result", bus.result_O, 32'h0000_0001);
    tick();
    run_shift(4'b0010, 32'h0000_0003, 32'd3);
    chk("sll3_latency", lat, 32'd3);
    chk("sll3_result", bus.result_O, 32'h0000_0018);
    tick();

    // Backpressure
    bus.ready_I = 1'b0;
    drive(4'b0101, 32'h0000_F0F0, 32'h0000_FF00);
    tick();
    chk("and_result", bus.result_O, 32'h0000_F000);
    drive(4'b0110, 32'h0000_000F, 32'h0000_00F0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", {31'b0, bus.ready_O}, 32'd0);
      tick();
      chk("bp_valid", {31'b0, bus.valid_O}, 32'd1);
      chk("bp_result", bus.result_O, 32'h0000_F000);
    end
    bus.ready_I = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, bus.ready_O}, 32'd1);
    tick();
    chk("bp_next_valid", {31'b0, bus.valid_O}, 32'd1);
    chk("bp_next_result", bus.result_O, 32'h0000_00FF);

    // Back-to-back
    drive(4'b0111, 32'hFF00_FF00, 32'h0FF0_0FF0);
    tick();
    chk("b2b_xor", bus.result_O, 32'hF0F0_F0F0);
    drive(4'b0110, 32'h0000_00F0, 32'h0000_0F00);
    tick();
    chk("b2b_or", bus.result_O, 32'h0000_0FF0);
    chk("b2b_or_valid", {31'b0, bus.valid_O}, 32'd1);
    drive(4'b0000, 32'd100, 32'd23);
    tick();
    chk("b2b_add", bus.result_O, 32'd123);
    bus.valid_I = 1'b0;
    tick();
    chk("b2b_drain", {31'b0, bus.valid_O}, 32'd0);

    // Flush mid-shift
    drive(4'b0010, 32'h1, 32'd10);
    tick();
    bus.valid_I = 1'b0;
    tick();
    bus.flush_I = 1'b1;
    #1;
    chk("flush_ready_low", {31'b0, bus.ready_O}, 32'd0);
    tick();
    bus.flush_I = 1'b0;
    chk("flush_valid", {31'b0, bus.valid_O}, 32'd0);
    #1;
    chk("flush_ready", {31'b0, bus.ready_O}, 32'd1);
    busy_bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.valid_O !== 1'b0) busy_bad = 1'b1;
    end
    chk("flush_no_late_result", {31'b0, busy_bad}, 32'd0);
    drive(4'b0000, 32'd2, 32'd3);
    tick();
    bus.valid_I = 1'b0;
    chk("flush_add", bus.result_O, 32'd5);
    chk("flush_add_valid", {31'b0, bus.valid_O}, 32'd1);
    tick();

    // Reset mid-shift
    drive(4'b0100, 32'hFFFF_FFFF, 32'd20);
    tick();
    bus.valid_I = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", {31'b0, bus.valid_O}, 32'd0);
    chk("rst_mid_result", bus.result_O, 32'd0);
    chk("rst_mid_zero", {31'b0, bus.zero_O}, 32'd1);
    #1;
    chk("rst_mid_ready", {31'b0, bus.ready_O}, 32'd1);
    busy_bad = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (bus.valid_O !== 1'b0) busy_bad = 1'b1;
    end
    chk("rst_mid_no_result", {31'b0, busy_bad}, 32'd0);

    // Undefined code after a nonzero result
    drive(4'b0000, 32'd1, 32'd1);
    tick();
    chk("pre_undef", bus.result_O, 32'd2);
    drive(4'b1111, 32'd123, 32'd456);
    tick();
    bus.valid_I = 1'b0;
    chk("undef_result", bus.result_O, 32'd0);
    chk("undef_zero", {31'b0, bus.zero_O}, 32'd1);
    chk("undef_valid", {31'b0, bus.valid_O}, 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit aluFunc code produced by ALU control and returns a registered result to the MEM stage.
- Add, sub, compare and logic ops complete in one cycle.
- Shifts use an area-saving bit-serial shifter, one bit per cycle.
- Valid/ready handshakes on both sides let the hazard unit stall the pipeline during multi-cycle shifts.

Parameters:
- XLEN, 32, operand and result width.
- SHAMT_W, 5, shift-amount width; must equal log2(XLEN).

Ports:
- clk_I  in  1  clock
- rst_I  in  1  synchronous active-high reset
- flush_I  in  1  pipeline flush; aborts the in-flight operation
- valid_I  in  1  upstream has an operation
- ready_O  out  1  unit can accept an operation this cycle
- aluFunc_I  in  4  function code
- opA_I  in  XLEN  operand A / shift source
- opB_I  in  XLEN  operand B; shamt = opB_I[SHAMT_W-1:0]
- valid_O  out  1  result_O holds an unconsumed result
- ready_I  in  1  downstream takes the result this cycle
- result_O  out  XLEN  registered result
- zero_O  out  1  registered (result_O == 0)

Behaviour:
- Function codes:
  - 0000 ADD; 0001 SUB (A-B, mod 2^XLEN).
  - 0010 SLL; 0100 SRL; 0011 SRA.
  - 1000 SLT (signed, result 1/0, zero-extended); 1001 SLTU (unsigned).
  - 0111 XOR; 0110 OR; 0101 AND.
  - Codes 1010-1111: result 0, single-cycle.
- Reset (rst_I=1 at an edge):
  - state=IDLE, valid_O=0, result_O=0, zero_O=1, count=0.
  - rst_I has priority over everything, including mid-shift.
- Output slot free: (!valid_O || ready_I).
- Handshake:
  - Accept at an edge when valid_I && ready_O.
  - ready_O = (state==IDLE) && slot free && !flush_I.
  - valid_O holds and result_O is stable while valid_O && !ready_I.
  - Consume when valid_O && ready_I; valid_O then drops unless a new result loads at the same edge.
- States:
  - IDLE:
    - Non-shift op, or shift with shamt=0: on accept, result_O/zero_O load the computed value and valid_O=1 after the accept edge. Latency 1; back-to-back throughput 1/cycle.
    - Shift with shamt>0: on accept, work=opA_I, count=shamt, op latched, go SHIFT. If the output was being consumed at this edge, valid_O=0.
  - SHIFT:
    - ready_O=0.
    - Each edge with count>1: work shifted 1 bit, count-1. SLL fills 0 at the LSB, SRL fills 0 at the MSB, SRA replicates work[XLEN-1].
    - Edge with count==1 and slot free: result_O = work shifted once, valid_O=1, go IDLE.
    - Edge with count==1 and slot not free: hold work and count unchanged (this cannot occur with a conforming upstream, because accept required the slot to be free; the rule is still mandatory).
    - Latency: valid_O rises shamt edges after the accept edge.
- Flush (flush_I=1, rst_I=0):
  - At the edge: valid_O=0, state=IDLE, count=0. Nothing is accepted that cycle.
  - result_O may keep a stale value.
  - flush_I beats a simultaneous consume or shift completion.
- Operands and aluFunc_I are sampled only at the accept edge. Changes during SHIFT have no effect.
- zero_O is always updated together with result_O.

Test Plan:
- Reset and single-cycle ops:
  - Reset -> valid_O=0, zero_O=1, ready_O=1.
  - ADD 0x7FFFFFFF+1 -> 0x80000000.
  - SUB 5-5 -> 0, zero_O=1.
  - SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
  - All valid 1 cycle after accept.
- Shifts:
  - SRA 0x80000000 by 4 -> 0xF8000000, valid_O 4 edges after accept, ready_O=0 throughout.
  - SRL 0x80000000 by 31 -> 0x00000001 at 31 edges.
  - SLL 0x1 by 0 -> 0x1 at 1 edge.
- Backpressure:
  - ready_I=0 for 3 cycles after an AND 0xF0F0&0xFF00 -> result 0xF000 held stable, ready_O=0.
  - ready_I=1 -> consumed, next op accepted at the same edge.
- Back-to-back: XOR, OR, ADD streamed with ready_I=1 -> three results on three consecutive cycles, no bubbles.
- Flush mid-shift: flush_I at the third cycle of SLL by 10 -> valid_O stays 0, state IDLE, ready_O=1 next cycle. A new ADD 2+3 returns 5.
- Reset mid-shift and undefined code:
  - rst_I during SRL by 20 -> all outputs at reset values next cycle.
  - aluFunc 1111 -> result 0, zero_O=1, 1-cycle latency.
